// File: rtl/matrix_decompiler.sv
// Receive-side matrix deframer: delimits RMII dibit frames, validates the header,
// emits row-major tagged elements and verifies the trailing modular checksum.
module matrix_decompiler #(
  parameter int ELEMENT_WIDTH  = 8,
  parameter int MAX_ROW_SIZE_A = 32,
  parameter int MAX_COL_SIZE_A = 32,
  parameter int MAX_ROW_SIZE_B = 32,
  parameter int MAX_COL_SIZE_B = 32
) (
  input  logic                     eth_refclk,
  input  logic                     rst_n,
  input  logic                     valid_data_in,
  input  logic [1:0]               dibit,
  output logic [ELEMENT_WIDTH-1:0] matrix_element,
  output logic                     element_valid,
  output logic [7:0]               row_idx,
  output logic [7:0]               col_idx,
  output logic                     matrix_sel,
  output logic [7:0]               num_rows,
  output logic [7:0]               num_cols,
  output logic                     frame_done,
  output logic                     frame_error
);

  localparam int EW = ELEMENT_WIDTH;
  localparam int PW = (EW > 2) ? EW - 2 : 1;
  localparam logic [3:0] ELEM_LAST = 4'(EW / 2 - 1);
  localparam logic [3:0] BYTE_LAST = 4'd3;
  localparam logic [7:0] ID_A      = 8'h0A;
  localparam logic [7:0] ID_B      = 8'h0B;
  localparam logic [7:0] MAX_RA    = 8'(MAX_ROW_SIZE_A);
  localparam logic [7:0] MAX_CA    = 8'(MAX_COL_SIZE_A);
  localparam logic [7:0] MAX_RB    = 8'(MAX_ROW_SIZE_B);
  localparam logic [7:0] MAX_CB    = 8'(MAX_COL_SIZE_B);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREAMB = 3'd1,
    S_HDR    = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  function automatic logic [EW-1:0] csum_add(input logic [EW-1:0] acc, input logic [EW-1:0] elem);
    return acc + elem;
  endfunction

  function automatic logic hdr_bad(input logic [7:0] id, input logic [7:0] rows, input logic [7:0] cols);
    logic [7:0] max_r;
    logic [7:0] max_c;
    max_r = (id == ID_B) ? MAX_RB : MAX_RA;
    max_c = (id == ID_B) ? MAX_CB : MAX_CA;
    return ((id != ID_A) && (id != ID_B)) || (rows == 8'd0) || (cols == 8'd0) ||
           (rows > max_r) || (cols > max_c);
  endfunction

  state_t          r_state, w_state;
  logic [1:0]      r_rst_sync;
  logic [2:0]      r_pre_cnt, w_pre_cnt;
  logic [3:0]      r_dib_cnt, w_dib_cnt;
  logic [1:0]      r_hdr_cnt, w_hdr_cnt;
  logic [PW-1:0]   r_part, w_part;
  logic [5:0]      r_byte, w_byte_part;
  logic [7:0]      r_id, w_id;
  logic [7:0]      r_rows_hdr, w_rows_hdr;
  logic [7:0]      r_row, w_row;
  logic [7:0]      r_col, w_col;
  logic [EW-1:0]   r_sum, w_sum;
  logic [EW-1:0]   w_elem_out;
  logic            w_elem_vld;
  logic [7:0]      w_row_idx, w_col_idx;
  logic            w_sel;
  logic [7:0]      w_nrows, w_ncols;
  logic            w_done, w_err;
  logic [7:0]      w_byte;
  logic [EW-1:0]   w_elem;
  logic [PW-1:0]   w_part_shift;

  // Current dibit completes the LSB-first shift of a byte or element.
  assign w_byte = {dibit, r_byte};

  if (EW > 2) begin : g_wide
    assign w_elem       = {dibit, r_part};
    assign w_part_shift = w_elem[EW-1:2];
  end else begin : g_narrow
    assign w_elem       = dibit;
    assign w_part_shift = r_part;
  end

  // Reset release is synchronised; assertion stays asynchronous.
  always_ff @(posedge eth_refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  // FSM state register.
  always_ff @(posedge eth_refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Next-state, datapath and strobe decode.
  always_comb begin
    w_state     = r_state;
    w_pre_cnt   = r_pre_cnt;
    w_dib_cnt   = r_dib_cnt;
    w_hdr_cnt   = r_hdr_cnt;
    w_part      = r_part;
    w_byte_part = r_byte;
    w_id        = r_id;
    w_rows_hdr  = r_rows_hdr;
    w_row       = r_row;
    w_col       = r_col;
    w_sum       = r_sum;
    w_elem_out  = '0;
    w_elem_vld  = 1'b0;
    w_row_idx   = 8'd0;
    w_col_idx   = 8'd0;
    w_sel       = matrix_sel;
    w_nrows     = num_rows;
    w_ncols     = num_cols;
    w_done      = 1'b0;
    w_err       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (valid_data_in && (dibit == 2'b01)) begin
          w_state   = S_PREAMB;
          w_pre_cnt = 3'd1;
          w_dib_cnt = 4'd0;
          w_hdr_cnt = 2'd0;
          w_row     = 8'd0;
          w_col     = 8'd0;
          w_sum     = '0;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_PREAMB: begin
        if (!valid_data_in) begin
          w_state = S_IDLE;
        end else if (dibit == 2'b01) begin
          w_pre_cnt = (r_pre_cnt == 3'd7) ? 3'd7 : r_pre_cnt + 3'd1;
        end else if ((dibit == 2'b11) && (r_pre_cnt >= 3'd4)) begin
          w_state = S_HDR;
        end else begin
          w_state = S_DRAIN;
        end
      end
      S_HDR: begin
        if (!valid_data_in) begin
          w_err   = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_byte_part = w_byte[7:2];
          if (r_dib_cnt == BYTE_LAST) begin
            w_dib_cnt = 4'd0;
            case (r_hdr_cnt)
              2'd0: begin
                w_id      = w_byte;
                w_hdr_cnt = 2'd1;
              end
              2'd1: begin
                w_rows_hdr = w_byte;
                w_hdr_cnt  = 2'd2;
              end
              default: begin
                w_hdr_cnt = 2'd0;
                if (hdr_bad(r_id, r_rows_hdr, w_byte)) begin
                  w_err   = 1'b1;
                  w_state = S_DRAIN;
                end else begin
                  w_sel   = (r_id == ID_B);
                  w_nrows = r_rows_hdr;
                  w_ncols = w_byte;
                  w_state = S_DATA;
                end
              end
            endcase
          end else begin
            w_dib_cnt = r_dib_cnt + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (!valid_data_in) begin
          w_err   = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_part = w_part_shift;
          if (r_dib_cnt == ELEM_LAST) begin
            w_dib_cnt  = 4'd0;
            w_elem_out = w_elem;
            w_elem_vld = 1'b1;
            w_row_idx  = r_row;
            w_col_idx  = r_col;
            w_sum      = csum_add(r_sum, w_elem);
            if (r_col == num_cols - 8'd1) begin
              w_col = 8'd0;
              if (r_row == num_rows - 8'd1) begin
                w_state = S_CHK;
              end else begin
                w_row = r_row + 8'd1;
              end
            end else begin
              w_col = r_col + 8'd1;
            end
          end else begin
            w_dib_cnt = r_dib_cnt + 4'd1;
          end
        end
      end
      S_CHK: begin
        if (!valid_data_in) begin
          w_err   = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_part = w_part_shift;
          if (r_dib_cnt == ELEM_LAST) begin
            w_dib_cnt = 4'd0;
            w_state   = S_DRAIN;
            if (w_elem == r_sum) begin
              w_done = 1'b1;
            end else begin
              w_err = 1'b1;
            end
          end else begin
            w_dib_cnt = r_dib_cnt + 4'd1;
          end
        end
      end
      S_DRAIN: begin
        if (!valid_data_in) begin
          w_state = S_IDLE;
        end else begin
          w_state = S_DRAIN;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Held in reset until the release has been synchronised.
    if (!r_rst_sync[1]) begin
      w_state     = S_IDLE;
      w_pre_cnt   = 3'd0;
      w_dib_cnt   = 4'd0;
      w_hdr_cnt   = 2'd0;
      w_part      = '0;
      w_byte_part = 6'd0;
      w_id        = 8'd0;
      w_rows_hdr  = 8'd0;
      w_row       = 8'd0;
      w_col       = 8'd0;
      w_sum       = '0;
      w_elem_out  = '0;
      w_elem_vld  = 1'b0;
      w_row_idx   = 8'd0;
      w_col_idx   = 8'd0;
      w_sel       = 1'b0;
      w_nrows     = 8'd0;
      w_ncols     = 8'd0;
      w_done      = 1'b0;
      w_err       = 1'b0;
    end else begin
      w_sel = w_sel;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge eth_refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt      <= 3'd0;
      r_dib_cnt      <= 4'd0;
      r_hdr_cnt      <= 2'd0;
      r_part         <= '0;
      r_byte         <= 6'd0;
      r_id           <= 8'd0;
      r_rows_hdr     <= 8'd0;
      r_row          <= 8'd0;
      r_col          <= 8'd0;
      r_sum          <= '0;
      matrix_element <= '0;
      element_valid  <= 1'b0;
      row_idx        <= 8'd0;
      col_idx        <= 8'd0;
      matrix_sel     <= 1'b0;
      num_rows       <= 8'd0;
      num_cols       <= 8'd0;
      frame_done     <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      r_pre_cnt      <= w_pre_cnt;
      r_dib_cnt      <= w_dib_cnt;
      r_hdr_cnt      <= w_hdr_cnt;
      r_part         <= w_part;
      r_byte         <= w_byte_part;
      r_id           <= w_id;
      r_rows_hdr     <= w_rows_hdr;
      r_row          <= w_row;
      r_col          <= w_col;
      r_sum          <= w_sum;
      matrix_element <= w_elem_out;
      element_valid  <= w_elem_vld;
      row_idx        <= w_row_idx;
      col_idx        <= w_col_idx;
      matrix_sel     <= w_sel;
      num_rows       <= w_nrows;
      num_cols       <= w_ncols;
      frame_done     <= w_done;
      frame_error    <= w_err;
    end
  end

endmodule

// File: tb/tb_matrix_decompiler.sv
// Directed scoreboard bench for matrix_decompiler: expected strobes are queued as
// stimulus is driven and matched, including cycle of arrival, when the DUT strobes.
module tb_matrix_decompiler;

  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_data_in = 1'b0;
  logic [1:0]    dibit = 2'b00;
  logic [EW-1:0] matrix_element;
  logic          element_valid;
  logic [7:0]    row_idx;
  logic [7:0]    col_idx;
  logic          matrix_sel;
  logic [7:0]    num_rows;
  logic [7:0]    num_cols;
  logic          frame_done;
  logic          frame_error;

  matrix_decompiler #(.ELEMENT_WIDTH(EW)) dut (
    .eth_refclk     (clk),
    .rst_n          (rst_n),
    .valid_data_in  (valid_data_in),
    .dibit          (dibit),
    .matrix_element (matrix_element),
    .element_valid  (element_valid),
    .row_idx        (row_idx),
    .col_idx        (col_idx),
    .matrix_sel     (matrix_sel),
    .num_rows       (num_rows),
    .num_cols       (num_cols),
    .frame_done     (frame_done),
    .frame_error    (frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // kind: 0 element, 1 frame_done, 2 frame_error
  typedef struct packed {
    logic [1:0]    kind;
    logic [EW-1:0] data;
    logic [7:0]    row;
    logic [7:0]    col;
    logic          sel;
    int            stamp;
  } ev_t;

  ev_t q[$];
  ev_t mon_o;
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [EW-1:0] d, input logic [7:0] r,
                      input logic [7:0] c, input logic s);
    q.push_back('{kind: k, data: d, row: r, col: c, sel: s, stamp: cyc + 1});
  endtask

  // Strobe monitor: each strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if ((element_valid === 1'b1) || (frame_done === 1'b1) || (frame_error === 1'b1)) begin
      mon_o.kind  = element_valid ? 2'd0 : (frame_done ? 2'd1 : 2'd2);
      mon_o.data  = element_valid ? matrix_element : '0;
      mon_o.row   = element_valid ? row_idx : 8'd0;
      mon_o.col   = element_valid ? col_idx : 8'd0;
      mon_o.sel   = element_valid ? matrix_sel : 1'b0;
      mon_o.stamp = cyc;
      checks++;
      assert (!(frame_done && frame_error)) else begin
        errors++;
        $error("FAIL done_and_error observed=1 expected=0");
      end
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_strobe observed kind=%0d data=%0h cyc=%0d expected none",
               mon_o.kind, mon_o.data, mon_o.stamp);
      end
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        checks++;
        assert (mon_o === mon_e) else begin
          errors++;
          $error("FAIL strobe observed k=%0d d=%0h r=%0d c=%0d s=%0b cyc=%0d expected k=%0d d=%0h r=%0d c=%0d s=%0b cyc=%0d",
                 mon_o.kind, mon_o.data, mon_o.row, mon_o.col, mon_o.sel, mon_o.stamp,
                 mon_e.kind, mon_e.data, mon_e.row, mon_e.col, mon_e.sel, mon_e.stamp);
        end
      end
    end
  end

  task automatic tx(input logic [1:0] d);
    @(negedge clk);
    valid_data_in = 1'b1;
    dibit = d;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_data_in = 1'b0;
      dibit = 2'b00;
    end
  endtask

  task automatic tx_bits(input logic [7:0] b, input int ndib);
    for (int i = 0; i < ndib; i++) tx(b[2*i +: 2]);
  endtask

  task automatic tx_hdr(input int npre, input logic [7:0] id, input logic [7:0] rows, input logic [7:0] cols);
    for (int i = 0; i < npre; i++) tx(2'b01);
    tx(2'b11);
    tx_bits(id, 4);
    tx_bits(rows, 4);
    tx_bits(cols, 4);
  endtask

  // Full frame; cut_elem >= 0 drops valid after 2 dibits of that element.
  task automatic tx_frame(input logic [7:0] id, input logic [7:0] rows, input logic [7:0] cols,
                          input logic [7:0] base, input logic [7:0] chk_delta, input int cut_elem);
    logic [7:0] sum;
    logic [7:0] e;
    logic       sel;
    int         idx;
    sel = (id == 8'h0B);
    sum = 8'd0;
    idx = 0;
    tx_hdr(4, id, rows, cols);
    for (int r = 0; r < int'(rows); r++) begin
      for (int c = 0; c < int'(cols); c++) begin
        e = base + 8'(idx);
        if (idx == cut_elem) begin
          tx_bits(e, 2);
          @(negedge clk);
          valid_data_in = 1'b0;
          push(2'd2, 8'd0, 8'd0, 8'd0, 1'b0);
          gap(2);
          return;
        end
        tx_bits(e, 4);
        push(2'd0, e, 8'(r), 8'(c), sel);
        sum = sum + e;
        idx++;
      end
    end
    tx_bits(sum + chk_delta, 4);
    push((chk_delta == 8'd0) ? 2'd1 : 2'd2, 8'd0, 8'd0, 8'd0, 1'b0);
    gap(3);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_elem"}, 32'(matrix_element), 32'd0);
    chk({tag, "_ev"}, 32'(element_valid), 32'd0);
    chk({tag, "_row"}, 32'(row_idx), 32'd0);
    chk({tag, "_col"}, 32'(col_idx), 32'd0);
    chk({tag, "_sel"}, 32'(matrix_sel), 32'd0);
    chk({tag, "_nrows"}, 32'(num_rows), 32'd0);
    chk({tag, "_ncols"}, 32'(num_cols), 32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_err"}, 32'(frame_error), 32'd0);
  endtask

  initial begin
    logic [7:0] e;
    gap(3);
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    gap(5);

    // 1: good A 2x2, checksum 0A
    tx_frame(8'h0A, 8'd2, 8'd2, 8'h01, 8'h00, -1);
    chk("t1_nrows", 32'(num_rows), 32'd2);
    chk("t1_ncols", 32'(num_cols), 32'd2);
    chk("t1_sel", 32'(matrix_sel), 32'd0);
    chk("t1_row_idle", 32'(row_idx), 32'd0);
    chk("t1_col_idle", 32'(col_idx), 32'd0);
    chk("t1_queue", 32'(q.size()), 32'd0);

    // 2: same frame, checksum 0B
    tx_frame(8'h0A, 8'd2, 8'd2, 8'h01, 8'h01, -1);
    chk("t2_queue", 32'(q.size()), 32'd0);

    // 3: valid dropped inside element 3, then good frame with checksum wrap
    tx_frame(8'h0A, 8'd2, 8'd2, 8'h01, 8'h00, 2);
    tx_frame(8'h0A, 8'd3, 8'd2, 8'hF0, 8'h00, -1);
    chk("t3_nrows", 32'(num_rows), 32'd3);
    chk("t3_queue", 32'(q.size()), 32'd0);

    // 4: ROWS=33 exceeds A limit; tail ignored
    tx_hdr(4, 8'h0A, 8'd33, 8'd2);
    push(2'd2, 8'd0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 6; i++) tx_bits(8'h5A, 4);
    gap(3);
    chk("t4_queue", 32'(q.size()), 32'd0);

    // 5: short preamble then body; a further valid frame stays drained
    tx_hdr(3, 8'h0A, 8'd2, 8'd2);
    for (int i = 0; i < 5; i++) tx_bits(8'h03, 4);
    tx_hdr(4, 8'h0A, 8'd1, 8'd1);
    tx_bits(8'h07, 4);
    tx_bits(8'h07, 4);
    gap(3);
    chk("t5_queue", 32'(q.size()), 32'd0);

    // 6: reset during DATA of B 3x3, then full B frame
    tx_hdr(4, 8'h0B, 8'd3, 8'd3);
    for (int i = 0; i < 4; i++) begin
      e = 8'h10 + 8'(i);
      tx_bits(e, 4);
      push(2'd0, e, 8'(i / 3), 8'(i % 3), 1'b1);
    end
    tx_bits(8'h14, 2);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    valid_data_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    gap(5);
    chk("t6_queue_rst", 32'(q.size()), 32'd0);
    tx_frame(8'h0B, 8'd3, 8'd3, 8'h20, 8'h00, -1);
    chk("t6_sel", 32'(matrix_sel), 32'd1);
    chk("t6_nrows", 32'(num_rows), 32'd3);
    chk("t6_ncols", 32'(num_cols), 32'd3);
    chk("final_queue", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
